// File: rtl/srl_fifo32x4_if.sv
// Handshake bundle for the 32x4 SRL FIFO: write side (d/wr/wrdy/afull),
// read side (y/yv/rd) and the total occupancy.
interface srl_fifo32x4_if;
   logic [3:0] d;
   logic       wr;
   logic       wrdy;
   logic       afull;
   logic [3:0] y;
   logic       yv;
   logic       rd;
   logic [5:0] level;

   modport master (
      output d, wr, rd,
      input  wrdy, afull, y, yv, level
   );

   modport slave (
      input  d, wr, rd,
      output wrdy, afull, y, yv, level
   );
endinterface

// File: rtl/srl_fifo32x4.sv
// 32-word x 4-bit FIFO: shift-register storage addressed at count-1, with a
// registered output stage presenting the oldest word over a valid/ready pair.
module srl_fifo32x4 #(
   parameter int unsigned AF_LEVEL = 24
) (
   input logic           clk,
   input logic           rstn,
   srl_fifo32x4_if.slave bus
);

   logic [3:0] srl [32];
   logic [5:0] count_q, count_d;
   logic       wrdy_q, wrdy_d;
   logic       afull_q, afull_d;
   logic [3:0] y_q, y_d;
   logic       yv_q, yv_d;
   logic [5:0] level_q, level_d;

   logic       push;
   logic       load;
   logic [4:0] raddr;
   logic [3:0] tap;

   assign push  = bus.wr & wrdy_q;
   assign load  = (count_q != 6'd0) & (~yv_q | bus.rd);
   // At count=32 the low bits wrap to 0, so count-1 lands on word 31.
   assign raddr = count_q[4:0] - 5'd1;
   assign tap   = srl[raddr];

   // Storage carries no reset; only occupancy decides what is meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         srl[0] <= bus.d;
         for (int k = 1; k < 32; k++) begin
            srl[k] <= srl[k-1];
         end
      end
   end

   always_comb begin
      count_d = count_q + {5'd0, push} - {5'd0, load};
      y_d     = y_q;
      yv_d    = yv_q;
      if (load) begin
         y_d  = tap;
         yv_d = 1'b1;
      end else if (yv_q && bus.rd) begin
         yv_d = 1'b0;
      end
      wrdy_d  = (count_d != 6'd32);
      afull_d = (32'(count_d) >= AF_LEVEL);
      level_d = count_d + {5'd0, yv_d};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= 6'd0;
         wrdy_q  <= 1'b1;
         afull_q <= 1'b0;
         y_q     <= 4'h0;
         yv_q    <= 1'b0;
         level_q <= 6'd0;
      end else begin
         count_q <= count_d;
         wrdy_q  <= wrdy_d;
         afull_q <= afull_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
         level_q <= level_d;
      end
   end

   assign bus.wrdy  = wrdy_q;
   assign bus.afull = afull_q;
   assign bus.y     = y_q;
   assign bus.yv    = yv_q;
   assign bus.level = level_q;

endmodule
